// File: rtl/syscall_ctrl.sv
// syscall_ctrl: stall-and-service engine for SYSCALL (print_string, print_char, exit).
// Latency: print_char finishes in 3 cycles; print_string takes 1 + per word (fetch wait + 1)
//          + one EMIT cycle per byte examined + 1 DONE cycle.
// Backpressure: mem_req/mem_addr held until mem_ack; cons_valid/cons_data held until cons_ready.
//
// Ports:
//   clk, rst_n                - clock, asynchronous active-low reset
//   syscall, vreg, areg       - decoder request level, $v0 service code, $a0 argument
//   mem_req/addr/rdata/ack    - word-aligned data-memory read port
//   cons_valid/data/ready     - byte-wide console output handshake
//   stall (combinational)     - freeze PC/pipeline while a service is in progress
//   done, err                 - one-cycle completion pulse, error flag alongside done
//   halt                      - sticky exit indication, cleared only by reset
module syscall_ctrl #(
  parameter int unsigned MAX_LEN = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        syscall,
  input  logic [31:0] vreg,
  input  logic [31:0] areg,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        cons_valid,
  output logic [7:0]  cons_data,
  input  logic        cons_ready,
  output logic        stall,
  output logic        done,
  output logic        halt,
  output logic        err
);

  // Byte counter must hold MAX_LEN itself; keep at least 9 bits.
  localparam int CW = ($clog2(MAX_LEN + 1) > 9) ? $clog2(MAX_LEN + 1) : 9;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHAR  = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_EMIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;

  localparam logic [31:0] SVC_PRINT_STR  = 32'd4;
  localparam logic [31:0] SVC_EXIT       = 32'd10;
  localparam logic [31:0] SVC_PRINT_CHAR = 32'd11;

  logic [2:0]    state_q, state_d;
  // ptr_q doubles as the latched $a0: string pointer for print_string,
  // character in [7:0] for print_char.
  logic [31:0]   ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   word_q, word_d;
  logic          eflag_q, eflag_d;

  logic          mem_req_q, mem_req_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic          cons_valid_q, cons_valid_d;
  logic [7:0]    cons_data_q, cons_data_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          halt_q, halt_d;

  logic [7:0]    byte_cur;
  logic [7:0]    byte_nxt;

  // Big-endian byte lane select: offset 0 is the most significant byte.
  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  assign byte_cur = pick_byte(word_q, ptr_q[1:0]);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    eflag_d = eflag_q;
    case (state_q)
      S_IDLE: begin
        if (syscall) begin
          ptr_d   = areg;
          cnt_d   = '0;
          eflag_d = 1'b0;
          case (vreg)
            SVC_PRINT_STR:  state_d = S_FETCH;
            SVC_PRINT_CHAR: state_d = S_CHAR;
            SVC_EXIT:       state_d = S_HALT;
            default: begin
              state_d = S_DONE;
              eflag_d = 1'b1;
            end
          endcase
        end
      end
      S_CHAR: begin
        if (cons_ready) state_d = S_DONE;
      end
      S_FETCH: begin
        if (mem_ack) begin
          word_d  = mem_rdata;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        // NUL check comes before the length check so that a string of exactly
        // MAX_LEN characters followed by NUL completes without error.
        if (byte_cur == 8'h00) begin
          state_d = S_DONE;
        end else if (cnt_q == MAX_CNT) begin
          state_d = S_DONE;
          eflag_d = 1'b1;
        end else if (cons_ready) begin
          ptr_d = ptr_q + 32'd1;
          cnt_d = cnt_q + CW'(1);
          if (ptr_d[1:0] == 2'b00) state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered: derive them from the state being entered so they
  // line up with that state in the following cycle.
  assign byte_nxt = pick_byte(word_d, ptr_d[1:0]);

  always_comb begin
    mem_req_d    = (state_d == S_FETCH);
    mem_addr_d   = mem_addr_q;
    cons_valid_d = 1'b0;
    cons_data_d  = cons_data_q;
    done_d       = (state_d == S_DONE);
    err_d        = (state_d == S_DONE) && eflag_d;
    halt_d       = (state_d == S_HALT);
    if (state_d == S_FETCH) mem_addr_d = {ptr_d[31:2], 2'b00};
    if (state_d == S_CHAR) begin
      cons_valid_d = 1'b1;
      cons_data_d  = ptr_d[7:0];
    end else if (state_d == S_EMIT) begin
      cons_valid_d = (byte_nxt != 8'h00) && (cnt_d != MAX_CNT);
      cons_data_d  = byte_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      word_q       <= '0;
      eflag_q      <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      cons_valid_q <= 1'b0;
      cons_data_q  <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      halt_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      eflag_q      <= eflag_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      cons_valid_q <= cons_valid_d;
      cons_data_q  <= cons_data_d;
      done_q       <= done_d;
      err_q        <= err_d;
      halt_q       <= halt_d;
    end
  end

  // Combinational so the SYSCALL decode cycle itself already freezes the PC.
  assign stall = ((state_q == S_IDLE) && syscall) ||
                 (state_q == S_CHAR) || (state_q == S_FETCH) ||
                 (state_q == S_EMIT) || (state_q == S_HALT);

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign cons_valid = cons_valid_q;
  assign cons_data  = cons_data_q;
  assign done       = done_q;
  assign err        = err_q;
  assign halt       = halt_q;

endmodule

// File: tb/tb_syscall_ctrl.sv
// tb_syscall_ctrl: directed + randomized checks of syscall_ctrl against a byte-stream model.
// Latency: checks exact done timing in zero-wait / always-ready runs.
// Backpressure: random memory wait states and console readiness, with hold-stability checks.
module tb_syscall_ctrl;
  localparam int unsigned MAX_LEN = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        syscall;
  logic [31:0] vreg, areg;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        cons_valid;
  logic [7:0]  cons_data;
  logic        cons_ready;
  logic        stall, done, halt, err;

  always #5 clk = ~clk;

  syscall_ctrl #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .syscall(syscall), .vreg(vreg), .areg(areg),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .cons_valid(cons_valid), .cons_data(cons_data), .cons_ready(cons_ready),
    .stall(stall), .done(done), .halt(halt), .err(err)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [logic [31:0]];
  logic [7:0]  exp_bytes[$];
  logic [7:0]  got_bytes[$];
  logic [31:0] exp_fetch[$];
  logic [31:0] got_fetch[$];
  logic        exp_err;

  int          ack_min = 0, ack_max = 0, ready_pct = 100, ack_wait = 0;
  logic        req_pend = 1'b0, cons_pend = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [7:0]  prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  task automatic set_byte(input logic [31:0] a, input logic [7:0] b);
    logic [31:0] w, cur;
    int sh;
    w   = {a[31:2], 2'b00};
    sh  = 8 * (3 - int'(a[1:0]));
    cur = rd(w);
    cur = (cur & ~(32'hFF << sh)) | ({24'h0, b} << sh);
    mem[w] = cur;
  endtask

  // Reference: walk bytes from a, stopping on NUL (no error) or after MAX_LEN
  // characters (error). Every byte position looked at needs its word fetched.
  task automatic model_string(input logic [31:0] a);
    logic [31:0] p, w, t;
    logic [7:0]  b;
    exp_bytes.delete();
    exp_fetch.delete();
    exp_err = 1'b0;
    for (int n = 0; n <= MAX_LEN; n++) begin
      p = a + 32'(n);
      w = {p[31:2], 2'b00};
      if (exp_fetch.size() == 0 || exp_fetch[$] != w) exp_fetch.push_back(w);
      t = rd(w) >> (8 * (3 - int'(p[1:0])));
      b = t[7:0];
      if (b == 8'h00) break;
      if (n == int'(MAX_LEN)) begin
        exp_err = 1'b1;
        break;
      end
      exp_bytes.push_back(b);
    end
  endtask

  // One clock: sample DUT on the falling edge, act as memory and console for
  // the next rising edge, and check that pending requests are held stable.
  task automatic tick();
    @(negedge clk);
    if (!rst_n) begin
      req_pend = 1'b0; cons_pend = 1'b0; mem_ack = 1'b0; cons_ready = 1'b0;
      return;
    end
    if (req_pend) begin
      chk("mem_req_hold", mem_req, 1);
      chk("mem_addr_hold", mem_addr, prev_addr);
    end
    if (mem_req) begin
      chk("mem_addr_align", {30'h0, mem_addr[1:0]}, 0);
      if (!req_pend) ack_wait = $urandom_range(ack_min, ack_max);
      prev_addr = mem_addr;
      if (ack_wait == 0) begin
        mem_ack = 1'b1;
        mem_rdata = rd(mem_addr);
        got_fetch.push_back(mem_addr);
        req_pend = 1'b0;
      end else begin
        ack_wait--;
        mem_ack = 1'b0;
        mem_rdata = $urandom;
        req_pend = 1'b1;
      end
    end else begin
      req_pend = 1'b0;
      mem_ack = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
    end
    if (cons_pend) begin
      chk("cons_valid_hold", cons_valid, 1);
      chk("cons_data_hold", cons_data, prev_data);
    end
    cons_ready = ($urandom_range(0, 99) < ready_pct);
    if (cons_valid) begin
      prev_data = cons_data;
      if (cons_ready) begin
        got_bytes.push_back(cons_data);
        cons_pend = 1'b0;
      end else begin
        cons_pend = 1'b1;
      end
    end else begin
      cons_pend = 1'b0;
    end
  endtask

  // Issue one syscall, hold it until done, then compare against expectations.
  task automatic run_sys(input string nm, input logic [31:0] v, input logic [31:0] a,
                         input int exp_cyc);
    bit found;
    int cyc;
    found = 0;
    cyc = 0;
    got_bytes.delete();
    got_fetch.delete();
    vreg = v;
    areg = a;
    syscall = 1'b1;
    #1;
    chk({nm, "_stall_c0"}, stall, 1);
    for (int k = 1; k <= 3000; k++) begin
      tick();
      if (done) begin
        found = 1;
        cyc = k;
        break;
      end
      chk({nm, "_stall_busy"}, stall, 1);
    end
    chk({nm, "_done_seen"}, 32'(found), 1);
    if (found) begin
      chk({nm, "_err"}, err, exp_err);
      chk({nm, "_stall_done"}, stall, 0);
      if (exp_cyc >= 0) chk({nm, "_done_cycle"}, cyc, exp_cyc);
    end
    syscall = 1'b0;
    tick();
    chk({nm, "_done_pulse"}, done, 0);
    chk({nm, "_err_pulse"}, err, 0);
    chk({nm, "_nbytes"}, got_bytes.size(), exp_bytes.size());
    for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++)
      chk($sformatf("%s_byte%0d", nm, i), got_bytes[i], exp_bytes[i]);
    chk({nm, "_nfetch"}, got_fetch.size(), exp_fetch.size());
    for (int i = 0; i < exp_fetch.size() && i < got_fetch.size(); i++)
      chk($sformatf("%s_fetch%0d", nm, i), got_fetch[i], exp_fetch[i]);
  endtask

  task automatic run_string(input string nm, input logic [31:0] a);
    int ideal;
    model_string(a);
    ideal = 1 + exp_fetch.size() + exp_bytes.size() + 1;
    run_sys(nm, 32'd4, a, (ack_max == 0 && ready_pct == 100) ? ideal : -1);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_mem_req"}, mem_req, 0);
    chk({nm, "_mem_addr"}, mem_addr, 0);
    chk({nm, "_cons_valid"}, cons_valid, 0);
    chk({nm, "_cons_data"}, cons_data, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_err"}, err, 0);
    chk({nm, "_halt"}, halt, 0);
  endtask

  initial begin
    logic [31:0] v, a;
    int len;
    bit seen;

    // Reset state.
    rst_n = 1'b0; syscall = 1'b0; vreg = '0; areg = '0;
    mem_rdata = '0; mem_ack = 1'b0; cons_ready = 1'b0;
    #1;
    check_reset_outputs("rst");
    chk("rst_stall_idle", stall, 0);
    syscall = 1'b1;
    #1;
    chk("rst_stall_syscall", stall, 1);
    syscall = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();

    // print_char: done at cycle 2.
    exp_bytes = '{8'h41}; exp_fetch.delete(); exp_err = 1'b0;
    run_sys("pchar", 32'd11, 32'h0000_0041, 2);

    // Unsupported code: done+err at cycle 1, no console traffic.
    exp_bytes.delete(); exp_fetch.delete(); exp_err = 1'b1;
    run_sys("unsup", 32'd99, 32'h1234_5678, 1);

    // Aligned string.
    mem.delete();
    mem[32'h100] = 32'h4869_0000;
    run_string("aligned", 32'h100);

    // Unaligned across words.
    mem.delete();
    mem[32'h100] = 32'h0000_0041;
    mem[32'h104] = 32'h4200_0000;
    run_string("unalign", 32'h103);

    // Same string with fixed 3-cycle memory wait and random console stalls.
    ack_min = 3; ack_max = 3; ready_pct = 50;
    run_string("bp_unalign", 32'h103);
    mem[32'h200] = 32'h6162_6364;
    mem[32'h204] = 32'h6500_0000;
    run_string("bp_long", 32'h201);
    ack_min = 0; ack_max = 0; ready_pct = 100;

    // Truncation: no NUL in 8 bytes.
    mem.delete();
    mem[32'h300] = 32'h4142_4344;
    mem[32'h304] = 32'h4546_4748;
    run_string("trunc", 32'h300);

    // Exactly MAX_LEN characters followed by NUL: no error.
    mem[32'h400] = 32'h3132_3334;
    mem[32'h404] = 32'h0000_0000;
    run_string("exact", 32'h400);

    // Empty string.
    mem[32'h500] = 32'h7700_0000;
    run_string("empty", 32'h501);

    // Pointer wrap through address 0.
    mem.delete();
    set_byte(32'hFFFF_FFFE, 8'h61);
    set_byte(32'hFFFF_FFFF, 8'h62);
    set_byte(32'h0000_0000, 8'h63);
    run_string("wrap", 32'hFFFF_FFFE);

    // Randomized services and environment.
    for (int it = 0; it < 40; it++) begin
      ack_min = 0;
      ack_max = $urandom_range(0, 3);
      ready_pct = (it % 3 == 0) ? 100 : $urandom_range(25, 90);
      case ($urandom_range(0, 5))
        0: begin
          v = 32'd11; a = $urandom;
          exp_bytes = '{a[7:0]}; exp_fetch.delete(); exp_err = 1'b0;
          run_sys("rnd_char", v, a, -1);
        end
        1: begin
          v = $urandom;
          if (v == 32'd4 || v == 32'd10 || v == 32'd11) v = 32'd7;
          exp_bytes.delete(); exp_fetch.delete(); exp_err = 1'b1;
          run_sys("rnd_unsup", v, $urandom, 1);
        end
        default: begin
          mem.delete();
          a = 32'h1000 + 32'(it * 16) + 32'($urandom_range(0, 3));
          len = $urandom_range(0, 6);
          for (int i = 0; i < len; i++) set_byte(a + 32'(i), 8'($urandom_range(1, 255)));
          run_string("rnd_str", a);
        end
      endcase
    end
    ack_min = 0; ack_max = 0; ready_pct = 100;

    // Exit: halt and stall persist even after syscall drops.
    vreg = 32'd10; areg = '0; syscall = 1'b1;
    #1;
    chk("halt_stall_c0", stall, 1);
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 3) syscall = 1'b0;
      chk($sformatf("halt_h%0d", i), halt, 1);
      chk($sformatf("halt_s%0d", i), stall, 1);
      chk($sformatf("halt_d%0d", i), done, 0);
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("halt_rst");
    chk("halt_rst_stall", stall, 0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of print_string.
    mem.delete();
    mem[32'h600] = 32'h5152_5354;
    mem[32'h604] = 32'h5556_5758;
    ack_min = 2; ack_max = 3; ready_pct = 40;
    vreg = 32'd4; areg = 32'h600; syscall = 1'b1;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (mem_req && got_fetch.size() > 0) begin
        seen = 1;
        break;
      end
    end
    chk("midrst_reached_fetch2", 32'(seen), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    chk("midrst_stall_syscall", stall, 1);
    syscall = 1'b0;
    #1;
    chk("midrst_stall_idle", stall, 0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    ack_min = 0; ack_max = 0; ready_pct = 100;
    tick();

    // Recovery after reset.
    exp_bytes = '{8'h5A}; exp_fetch.delete(); exp_err = 1'b0;
    run_sys("post_rst_char", 32'd11, 32'h0000_005A, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute guard so the run always ends on its own.
  initial begin
    #2000000;
    failures++;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "global timeout");
  end

endmodule
